// File: rtl/sync_load_ctl_if.sv
// Handshake bundle between the async source, sync_load_ctl and the downstream loadable register.
interface sync_load_ctl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             clk;
  logic             req_async;
  logic [WIDTH-1:0] data_async;
  logic [WIDTH-1:0] d;
  logic             ld;
  logic             ack_async;
  logic             busy;

  modport master (
    output clk, req_async, data_async,
    input  d, ld, ack_async, busy
  );

  modport slave (
    input  clk, req_async, data_async,
    output d, ld, ack_async, busy
  );
endinterface

// File: rtl/sync_load_ctl.sv
// Toggle req/ack receiver: synchronises an async request, waits a settle window,
// captures the data word and holds it with a load strobe until the downstream enable takes it.
module sync_load_ctl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 2
) (
  input  logic           sys_clk,
  input  logic           rst,
  sync_load_ctl_if.slave bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOAD   = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync_req;

  state_t             r_state,    w_state_nx;
  logic               r_req_seen, w_req_seen_nx;
  logic [CNT_W-1:0]   r_cnt,      w_cnt_nx;
  logic [WIDTH-1:0]   r_d,        w_d_nx;
  logic               r_ld,       w_ld_nx;
  logic               r_ack,      w_ack_nx;
  logic               r_busy,     w_busy_nx;

  // Request synchroniser; the only place req_async is sampled.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.req_async};
    end
  end

  assign w_sync_req = r_sync[SYNC_STAGES-1];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_req_seen <= 1'b0;
      r_cnt      <= '0;
      r_d        <= '0;
      r_ld       <= 1'b0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_req_seen <= w_req_seen_nx;
      r_cnt      <= w_cnt_nx;
      r_d        <= w_d_nx;
      r_ld       <= w_ld_nx;
      r_ack      <= w_ack_nx;
      r_busy     <= w_busy_nx;
    end
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nx    = r_state;
    w_req_seen_nx = r_req_seen;
    w_cnt_nx      = r_cnt;
    w_d_nx        = r_d;
    w_ld_nx       = r_ld;
    w_ack_nx      = r_ack;

    case (r_state)
      ST_IDLE: begin
        if (w_sync_req != r_req_seen) begin
          w_req_seen_nx = w_sync_req;
          w_cnt_nx      = CNT_W'(SETTLE);
          w_state_nx    = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_cnt == '0) begin
          w_d_nx     = bus.data_async;
          w_ld_nx    = 1'b1;
          w_state_nx = ST_LOAD;
        end else begin
          w_cnt_nx = r_cnt - CNT_W'(1);
        end
      end
      ST_LOAD: begin
        // Downstream may stall indefinitely; strobe and data stay put until taken.
        if (bus.clk) begin
          w_ld_nx    = 1'b0;
          w_state_nx = ST_ACK;
        end
      end
      ST_ACK: begin
        w_ack_nx   = ~r_ack;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_ld_nx    = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase

    w_busy_nx = (w_state_nx != ST_IDLE);
  end

  assign bus.d         = r_d;
  assign bus.ld        = r_ld;
  assign bus.ack_async = r_ack;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_sync_load_ctl.sv
// Directed bench for sync_load_ctl: one instance with SETTLE=2, one with SETTLE=0.
module tb_sync_load_ctl;

  localparam int unsigned WIDTH = 8;

  logic sys_clk = 1'b0;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_q[$];

  sync_load_ctl_if #(.WIDTH(WIDTH)) bus_a ();
  sync_load_ctl_if #(.WIDTH(WIDTH)) bus_b ();

  sync_load_ctl #(.WIDTH(WIDTH), .SYNC_STAGES(2), .SETTLE(2)) u_dut_a (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_a)
  );

  sync_load_ctl #(.WIDTH(WIDTH), .SYNC_STAGES(2), .SETTLE(0)) u_dut_b (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus_b)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 time unit past the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  function automatic logic get_ld(input bit sel);
    return sel ? bus_b.ld : bus_a.ld;
  endfunction

  function automatic logic [WIDTH-1:0] get_d(input bit sel);
    return sel ? bus_b.d : bus_a.d;
  endfunction

  task automatic wait_ld(input bit sel, input string tag);
    int k = 0;
    while (!get_ld(sel) && k < 40) begin
      step(1);
      k++;
    end
    check({tag, "_ld_seen"}, 32'(get_ld(sel)), 32'd1);
  endtask

  // Scoreboard pop on an observed load.
  task automatic check_load(input bit sel, input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_d"}, 32'(get_d(sel)), 32'(e));
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus_a.clk        = 1'b1;
    bus_a.req_async  = 1'b0;
    bus_a.data_async = '0;
    bus_b.clk        = 1'b1;
    bus_b.req_async  = 1'b0;
    bus_b.data_async = '0;
    step(2);
    check("rst_d",    32'(bus_a.d),         32'd0);
    check("rst_ld",   32'(bus_a.ld),        32'd0);
    check("rst_ack",  32'(bus_a.ack_async), 32'd0);
    check("rst_busy", 32'(bus_a.busy),      32'd0);
    check("rst_b_ld", 32'(bus_b.ld),        32'd0);
    rst = 1'b0;

    // T1: basic request, exact latency.
    bus_a.data_async = 8'hA5;
    bus_a.req_async  = 1'b1;
    exp_q.push_back(8'hA5);
    step(5);
    check("t1_ld_e5",   32'(bus_a.ld),   32'd0);
    check("t1_busy_e5", 32'(bus_a.busy), 32'd1);
    step(1);
    check("t1_ld_e6", 32'(bus_a.ld), 32'd1);
    check_load(1'b0, "t1");
    step(1);
    check("t1_ld_e7",  32'(bus_a.ld),        32'd0);
    check("t1_ack_e7", 32'(bus_a.ack_async), 32'd0);
    check("t1_busy_e7", 32'(bus_a.busy),     32'd1);
    step(1);
    check("t1_ack_e8",  32'(bus_a.ack_async), 32'd1);
    check("t1_busy_e8", 32'(bus_a.busy),      32'd0);

    // T5: reset while in LOAD; req left at 1 so the request is re-served.
    bus_a.data_async = 8'h77;
    bus_a.clk        = 1'b0;
    bus_a.req_async  = 1'b0;
    step(6);
    check("t5_in_load_ld", 32'(bus_a.ld), 32'd1);
    check("t5_in_load_d",  32'(bus_a.d),  32'h77);
    rst             = 1'b1;
    bus_a.req_async = 1'b1;
    step(1);
    check("t5_rst_d",    32'(bus_a.d),         32'd0);
    check("t5_rst_ld",   32'(bus_a.ld),        32'd0);
    check("t5_rst_ack",  32'(bus_a.ack_async), 32'd0);
    check("t5_rst_busy", 32'(bus_a.busy),      32'd0);
    rst       = 1'b0;
    bus_a.clk = 1'b1;
    exp_q.push_back(8'h77);
    wait_ld(1'b0, "t5");
    check_load(1'b0, "t5");
    step(1);
    check("t5_ld_off", 32'(bus_a.ld), 32'd0);
    step(1);
    check("t5_ack",  32'(bus_a.ack_async), 32'd1);
    check("t5_busy", 32'(bus_a.busy),      32'd0);

    // T2: downstream stalls 5 cycles with the strobe up.
    bus_a.data_async = 8'hA5;
    bus_a.clk        = 1'b0;
    bus_a.req_async  = 1'b0;
    exp_q.push_back(8'hA5);
    step(5);
    check("t2_ld_e5", 32'(bus_a.ld), 32'd0);
    step(1);
    check("t2_ld_e6", 32'(bus_a.ld), 32'd1);
    check_load(1'b0, "t2");
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("t2_hold_ld_%0d", i), 32'(bus_a.ld), 32'd1);
      check($sformatf("t2_hold_d_%0d", i),  32'(bus_a.d),  32'hA5);
    end
    bus_a.clk = 1'b1;
    step(1);
    check("t2_ld_off",  32'(bus_a.ld),        32'd0);
    check("t2_ack_pre", 32'(bus_a.ack_async), 32'd1);
    step(1);
    check("t2_ack",  32'(bus_a.ack_async), 32'd0);
    check("t2_busy", 32'(bus_a.busy),      32'd0);

    // T4: second toggle arrives during LOAD of the first.
    bus_a.data_async = 8'h11;
    bus_a.req_async  = 1'b1;
    exp_q.push_back(8'h11);
    wait_ld(1'b0, "t4a");
    check_load(1'b0, "t4a");
    bus_a.req_async  = 1'b0;
    bus_a.data_async = 8'h22;
    exp_q.push_back(8'h22);
    step(1);
    check("t4a_ld_off", 32'(bus_a.ld), 32'd0);
    step(1);
    check("t4a_ack", 32'(bus_a.ack_async), 32'd1);
    wait_ld(1'b0, "t4b");
    check_load(1'b0, "t4b");
    step(1);
    check("t4b_ld_off", 32'(bus_a.ld), 32'd0);
    step(1);
    check("t4b_ack",  32'(bus_a.ack_async), 32'd0);
    check("t4b_busy", 32'(bus_a.busy),      32'd0);

    // T6: only the value present at the SETTLE-exit edge is captured.
    bus_a.data_async = 8'h00;
    bus_a.req_async  = 1'b1;
    exp_q.push_back(8'hFF);
    step(4);
    bus_a.data_async = 8'hFF;
    step(2);
    check("t6_ld_e6", 32'(bus_a.ld), 32'd1);
    check_load(1'b0, "t6");
    bus_a.data_async = 8'h55;
    step(1);
    check("t6_d_held", 32'(bus_a.d),  32'hFF);
    check("t6_ld_off", 32'(bus_a.ld), 32'd0);
    step(1);
    check("t6_ack", 32'(bus_a.ack_async), 32'd1);

    // T3: SETTLE=0, back-to-back requests.
    bus_b.data_async = 8'h3C;
    bus_b.req_async  = 1'b1;
    exp_q.push_back(8'h3C);
    step(3);
    check("t3a_ld_e3", 32'(bus_b.ld), 32'd0);
    step(1);
    check("t3a_ld_e4", 32'(bus_b.ld), 32'd1);
    check_load(1'b1, "t3a");
    step(1);
    check("t3a_ld_off", 32'(bus_b.ld), 32'd0);
    step(1);
    check("t3a_ack",  32'(bus_b.ack_async), 32'd1);
    check("t3a_busy", 32'(bus_b.busy),      32'd0);
    bus_b.data_async = 8'hC3;
    bus_b.req_async  = 1'b0;
    exp_q.push_back(8'hC3);
    wait_ld(1'b1, "t3b");
    check_load(1'b1, "t3b");
    step(2);
    check("t3b_ack", 32'(bus_b.ack_async), 32'd0);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_load_ctl.md
Name: sync_load_ctl

Overview:
- Upstream feeder for the loadable resettable register stage (fd2e-based, `ti`/`te` load path).
- Accepts a data word from an asynchronous source using a toggle request/acknowledge handshake.
- Synchronises the request into the `sys_clk` domain, waits a settle window, then captures the data.
- Presents the data on `d` with a one-stage load strobe `ld`, held until the downstream clock-enable `clk` accepts it.

Parameters:
- WIDTH, 8: data word width.
- SYNC_STAGES, 2: request synchroniser depth; legal range 2..4.
- SETTLE, 2: extra `sys_clk` cycles waited after the request is detected, before data capture; legal range 0..15.

Ports:
- sys_clk  in  1  single system clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- clk  in  1  downstream register clock-enable; `ld` is consumed on a `sys_clk` edge where `clk`=1.
- req_async  in  1  toggle request from the async source; each level change is one request.
- data_async  in  WIDTH  async data; stable from the req toggle until the ack toggle.
- d  out  WIDTH  captured data to the downstream `ti` input.
- ld  out  1  load strobe to the downstream `te` input.
- ack_async  out  1  acknowledge toggle back to the source.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (`rst`=1 at an edge):
  - state=IDLE; sync chain=0; req_seen=0; cnt=0.
  - d=0, ld=0, ack_async=0, busy=0.
  - Reset wins over every other event, including mid-transfer; partial transfers are dropped with no ack toggle.
- Synchroniser:
  - SYNC_STAGES flops; sync_req is the last stage.
  - No other logic samples `req_async` directly.
- FSM, all outputs registered:
  - IDLE: if sync_req != req_seen, then req_seen<=sync_req, cnt<=SETTLE, go to SETTLE. Otherwise stay.
  - SETTLE: if cnt==0, then d<=data_async, ld<=1, go to LOAD. Otherwise cnt<=cnt-1.
  - LOAD: ld held at 1 and d held constant. On an edge with clk=1: ld<=0, go to ACK. With clk=0: stay, with no limit on the wait.
  - ACK: ack_async<=~ack_async, go to IDLE.
- Latency (SYNC_STAGES=2, SETTLE=2), req toggled before edge 1:
  - sync_req=1 after edge 2.
  - SETTLE entered at edge 3; cnt reaches 0 at edge 5.
  - d valid and ld=1 after edge 6.
  - With clk=1 at edge 7: ld=0 after edge 7; ack_async toggles after edge 8.
  - General form: ld rises SYNC_STAGES+SETTLE+2 edges after the toggle is first sampled.
- SETTLE=0: SETTLE lasts exactly one cycle.
- ld is never high outside LOAD. Exactly one accepted load (ld=1 and clk=1 on the same edge) per request.
- req toggles while busy:
  - Not lost if the level differs from req_seen when IDLE is re-entered; it is then served as the next request.
  - Two toggles while busy cancel out (protocol violation; no response required).
- After reset with req_async=1: treated as a pending request and served normally, ending with ack_async=1.
- data_async changes outside the stable window are ignored. Only the value at the SETTLE-exit edge is captured.
- busy=1 from the IDLE->SETTLE edge until the ACK->IDLE edge.

Test Plan:
1. Reset, clk held 1, req 0->1 with data_async=8'hA5 -> ld=1 for exactly 1 cycle after edge 6, d=8'hA5, ack_async 0->1 after edge 8, busy low after edge 8.
2. Same as 1 but clk=0 for 5 cycles after ld rises -> ld and d=8'hA5 held 5 extra cycles; ld falls on the first edge with clk=1; ack follows one edge later.
3. SETTLE=0; two back-to-back requests (1->0 after ack, data 8'h3C then 8'hC3) -> two ld pulses with the correct d; ack_async 1 then 0.
4. Toggle req during LOAD of the first request (data 8'h11, then 8'h22) -> second request served after returning to IDLE, d=8'h22; total 2 ack toggles.
5. rst pulsed while in LOAD -> after the edge: ld=0, d=0, ack_async=0, busy=0; no ack toggle. If req_async=1 remains, the request is re-served (ld pulse, ack_async=1).
6. data_async changed from 8'h00 to 8'hFF one cycle before the SETTLE-exit edge, and to 8'h55 after it -> d=8'hFF.
